// File: rtl/proc_mc_if.sv
// ============================================================================
// Module   : proc_mc_if
// Purpose  : Shared instruction/data memory req/ack bus for proc_mc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface proc_mc_if #(
    parameter int ADDR_W = 8
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/proc_mc.sv
// ============================================================================
// Module   : proc_mc
// Purpose  : Multi-cycle 16-bit-instruction processor with req/ack memory bus.
//            PROC_MC_ILLEGAL_TRAP_EN: reserved opcodes B-E halt instead of NOP.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_mc #(
    parameter int DATA_W    = 8,
    parameter int NREGS     = 16,
    parameter int ADDR_W    = 8,
    parameter int DATA_BASE = 'h80,
    parameter int RESET_PC  = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    proc_mc_if.master              mem,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   halted,
    output logic [ADDR_W-1:0]      pc_dbg
);

    localparam int                c_RIDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [ADDR_W-1:0] c_RESET_PC  = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_DATA_BASE = ADDR_W'(DATA_BASE);
    localparam logic [ADDR_W-1:0] c_PC_ONE    = ADDR_W'(1);

    localparam logic [3:0] c_OP_LI   = 4'h1;
    localparam logic [3:0] c_OP_LD   = 4'h2;
    localparam logic [3:0] c_OP_ST   = 4'h3;
    localparam logic [3:0] c_OP_ADD  = 4'h4;
    localparam logic [3:0] c_OP_SUB  = 4'h5;
    localparam logic [3:0] c_OP_AND  = 4'h6;
    localparam logic [3:0] c_OP_XOR  = 4'h7;
    localparam logic [3:0] c_OP_BEQZ = 4'h8;
    localparam logic [3:0] c_OP_JMP  = 4'h9;
    localparam logic [3:0] c_OP_OUT  = 4'hA;
    localparam logic [3:0] c_OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_IWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_DREQ  = 3'd3,
        S_DWAIT = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [15:0]       r_ir;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_halted;
    logic [DATA_W-1:0] r_regs [NREGS];

    // r0 and indices beyond the implemented file read as zero.
    function automatic logic [DATA_W-1:0] f_rd(input logic [3:0] idx);
        if (idx == 4'd0 || int'(idx) >= NREGS)
            return '0;
        return r_regs[idx[c_RIDX_W-1:0]];
    endfunction

    function automatic logic f_wr_ok(input logic [3:0] idx);
        return (idx != 4'd0) && (int'(idx) < NREGS);
    endfunction

    logic [3:0]        w_op;
    logic [3:0]        w_rd;
    logic [3:0]        w_rs;
    logic [3:0]        w_rt;
    logic [7:0]        w_imm8;
    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_alu;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_data_addr;

    assign w_op        = r_ir[15:12];
    assign w_rd        = r_ir[11:8];
    assign w_rs        = r_ir[7:4];
    assign w_rt        = r_ir[3:0];
    assign w_imm8      = r_ir[7:0];
    assign w_a         = f_rd(w_rs);
    assign w_b         = f_rd(w_rt);
    assign w_pc_inc    = r_pc + c_PC_ONE;
    assign w_br_off    = ADDR_W'($signed(w_imm8));
    assign w_data_addr = c_DATA_BASE + ADDR_W'(w_imm8);

    always_comb begin
        w_alu = '0;
        case (w_op)
            c_OP_ADD: w_alu = w_a + w_b;
            c_OP_SUB: w_alu = w_a - w_b;
            c_OP_AND: w_alu = w_a & w_b;
            c_OP_XOR: w_alu = w_a ^ w_b;
            default:  w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_pc        <= c_RESET_PC;
            r_ir        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_halted    <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= r_pc;
                    r_state    <= S_IWAIT;
                end
                S_IWAIT: begin
                    if (mem.mem_ack) begin
                        r_ir      <= mem.mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_EXEC;
                        // Raise OUT here so the pulse coincides with its EXEC cycle.
                        if (mem.mem_rdata[15:12] == c_OP_OUT) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= f_rd(mem.mem_rdata[7:4]);
                        end
                    end
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    r_pc    <= w_pc_inc;
                    case (w_op)
                        c_OP_LI: begin
                            if (f_wr_ok(w_rd))
                                r_regs[w_rd[c_RIDX_W-1:0]] <= DATA_W'(w_imm8);
                        end
                        c_OP_LD, c_OP_ST: begin
                            r_pc    <= r_pc;
                            r_state <= S_DREQ;
                        end
                        c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_XOR: begin
                            if (f_wr_ok(w_rd))
                                r_regs[w_rd[c_RIDX_W-1:0]] <= w_alu;
                        end
                        c_OP_BEQZ: begin
                            if (f_rd(w_rd) == '0)
                                r_pc <= w_pc_inc + w_br_off;
                        end
                        c_OP_JMP: r_pc <= ADDR_W'(r_ir[11:0]);
                        c_OP_HALT: begin
                            r_pc     <= r_pc;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
`ifdef PROC_MC_ILLEGAL_TRAP_EN
                        4'hB, 4'hC, 4'hD, 4'hE: begin
                            r_pc     <= r_pc;
                            r_halted <= 1'b1;
                            r_state  <= S_HALT;
                        end
`endif
                        default: ;
                    endcase
                end
                S_DREQ: begin
                    r_mem_req  <= 1'b1;
                    r_mem_we   <= (w_op == c_OP_ST);
                    r_mem_addr <= w_data_addr;
                    if (w_op == c_OP_ST)
                        r_mem_wdata <= 16'(f_rd(w_rd));
                    r_state    <= S_DWAIT;
                end
                S_DWAIT: begin
                    if (mem.mem_ack) begin
                        if (w_op == c_OP_LD && f_wr_ok(w_rd))
                            r_regs[w_rd[c_RIDX_W-1:0]] <= mem.mem_rdata[DATA_W-1:0];
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_pc      <= w_pc_inc;
                        r_state   <= S_FETCH;
                    end
                end
                S_HALT:  ;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign halted        = r_halted;
    assign pc_dbg        = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_proc_mc.sv
// ============================================================================
// Module   : tb_proc_mc
// Purpose  : Directed self-checking bench for proc_mc with a variable-latency
//            memory model. Honours PROC_MC_ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_proc_mc;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              halted;
    logic [ADDR_W-1:0] pc_dbg;

    always #5 clk = ~clk;

    proc_mc_if #(.ADDR_W(ADDR_W)) mif ();

    proc_mc #(
        .DATA_W(DATA_W), .NREGS(16), .ADDR_W(ADDR_W), .DATA_BASE('h80), .RESET_PC(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem       (mif),
        .out_valid (out_valid),
        .out_data  (out_data),
        .halted    (halted),
        .pc_dbg    (pc_dbg)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Program image written only by the test sequence.
    logic [15:0] prog [256];
    int          ack_delay = 0;

    // Memory model state, written only by the model process.
    logic [15:0]       dmem   [256];
    logic              dvalid [256];
    int                cnt = 0;
    int                wr_cnt = 0;
    int                stab_err = 0;
    logic [ADDR_W-1:0] last_waddr = '0;
    logic [15:0]       last_wdata = '0;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [15:0]       cap_wdata;

    always @(negedge clk) begin
        if (rst || !mif.mem_req) begin
            mif.mem_ack = 1'b0;
            cnt = 0;
            if (rst)
                for (int i = 0; i < 256; i++) dvalid[i] = 1'b0;
        end else if (mif.mem_ack) begin
            mif.mem_ack = 1'b0;
            cnt = 0;
        end else begin
            if (cnt == 0) begin
                cap_addr  = mif.mem_addr;
                cap_we    = mif.mem_we;
                cap_wdata = mif.mem_wdata;
            end else if (mif.mem_addr !== cap_addr || mif.mem_we !== cap_we ||
                         mif.mem_wdata !== cap_wdata) begin
                stab_err++;
            end
            if (cnt == ack_delay) begin
                mif.mem_ack   = 1'b1;
                mif.mem_rdata = dvalid[mif.mem_addr] ? dmem[mif.mem_addr] : prog[mif.mem_addr];
                if (mif.mem_we) begin
                    dmem[mif.mem_addr]   = mif.mem_wdata;
                    dvalid[mif.mem_addr] = 1'b1;
                    last_waddr = mif.mem_addr;
                    last_wdata = mif.mem_wdata;
                    wr_cnt++;
                end
            end else begin
                cnt++;
            end
        end
    end

    logic [DATA_W-1:0] outs [256];
    int                n_out = 0;

    always @(negedge clk) begin
        if (out_valid && !rst) begin
            if (n_out < 256) outs[n_out] = out_data;
            n_out++;
        end
    end

    task automatic hold_reset(input int delay);
        rst = 1'b1;
        ack_delay = delay;
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input int max_cycles, input string name);
        int c;
        for (c = 0; c < max_cycles && !halted; c++) @(negedge clk);
        n_checks++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_halt: halted=%b expected 1 after %0d cycles", name, halted, c);
        end
    endtask

    task automatic test_reset();
        hold_reset(0);
        @(negedge clk);
        n_checks += 8;
        if (mif.mem_req !== 1'b0)   begin n_fail++; $display("FAIL rst_mem_req: got %b exp 0", mif.mem_req); end
        if (mif.mem_we !== 1'b0)    begin n_fail++; $display("FAIL rst_mem_we: got %b exp 0", mif.mem_we); end
        if (mif.mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr: got %h exp 00", mif.mem_addr); end
        if (mif.mem_wdata !== 16'h0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h exp 0000", mif.mem_wdata); end
        if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        if (out_data !== 8'h00)     begin n_fail++; $display("FAIL rst_out_data: got %h exp 00", out_data); end
        if (halted !== 1'b0)        begin n_fail++; $display("FAIL rst_halted: got %b exp 0", halted); end
        if (pc_dbg !== 8'h00)       begin n_fail++; $display("FAIL rst_pc: got %h exp 00", pc_dbg); end
    endtask

    task automatic test_alu_basic();
        int o0;
        int cyc_out  = -1;
        int cyc_halt = -1;
        hold_reset(0);
        prog[0] = 16'h1105; prog[1] = 16'h1203; prog[2] = 16'h4312;
        prog[3] = 16'hA030; prog[4] = 16'hF000;
        o0 = n_out;
        release_reset();
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (out_valid && cyc_out < 0) cyc_out = c;
            if (halted) begin cyc_halt = c; break; end
        end
        n_checks += 5;
        if (cyc_out != 11)  begin n_fail++; $display("FAIL alu_out_cycle: got %0d exp 11", cyc_out); end
        if (cyc_halt != 15) begin n_fail++; $display("FAIL alu_halt_cycle: got %0d exp 15", cyc_halt); end
        if (n_out - o0 != 1) begin n_fail++; $display("FAIL alu_out_count: got %0d exp 1", n_out - o0); end
        if (outs[o0] !== 8'h08) begin n_fail++; $display("FAIL alu_out_data: got %h exp 08", outs[o0]); end
        if (out_data !== 8'h08) begin n_fail++; $display("FAIL alu_out_hold: got %h exp 08", out_data); end
    endtask

    task automatic test_ld_st();
        int o0, w0, s0;
        hold_reset(3);
        prog[0] = 16'h11AA; prog[1] = 16'h3110; prog[2] = 16'h2410;
        prog[3] = 16'hA040; prog[4] = 16'hF000;
        o0 = n_out; w0 = wr_cnt; s0 = stab_err;
        release_reset();
        wait_halt(300, "ldst");
        n_checks += 5;
        if (wr_cnt - w0 != 1)       begin n_fail++; $display("FAIL ldst_wr_count: got %0d exp 1", wr_cnt - w0); end
        if (last_waddr !== 8'h90)   begin n_fail++; $display("FAIL ldst_waddr: got %h exp 90", last_waddr); end
        if (last_wdata !== 16'h00AA) begin n_fail++; $display("FAIL ldst_wdata: got %h exp 00aa", last_wdata); end
        if (outs[o0] !== 8'hAA)     begin n_fail++; $display("FAIL ldst_out: got %h exp aa", outs[o0]); end
        if (stab_err != s0)         begin n_fail++; $display("FAIL ldst_stable: got %0d exp 0", stab_err - s0); end
    endtask

    task automatic test_wrap_arith();
        int o0;
        hold_reset(1);
        prog[0] = 16'h11FF; prog[1] = 16'h1202; prog[2] = 16'h4312; prog[3] = 16'hA030;
        prog[4] = 16'h1501; prog[5] = 16'h5405; prog[6] = 16'hA040; prog[7] = 16'hF000;
        o0 = n_out;
        release_reset();
        wait_halt(200, "wrap");
        n_checks += 3;
        if (n_out - o0 != 2)    begin n_fail++; $display("FAIL wrap_count: got %0d exp 2", n_out - o0); end
        if (outs[o0] !== 8'h01)   begin n_fail++; $display("FAIL wrap_add: got %h exp 01", outs[o0]); end
        if (outs[o0+1] !== 8'hFF) begin n_fail++; $display("FAIL wrap_sub: got %h exp ff", outs[o0+1]); end
    endtask

    task automatic test_countdown();
        int o0;
        hold_reset(1);
        prog[0] = 16'h1103; prog[1] = 16'h1201; prog[2] = 16'h5112; prog[3] = 16'hA010;
        prog[4] = 16'h8101; prog[5] = 16'h9002; prog[6] = 16'hF000;
        o0 = n_out;
        release_reset();
        wait_halt(400, "loop");
        n_checks += 4;
        if (n_out - o0 != 3)      begin n_fail++; $display("FAIL loop_count: got %0d exp 3", n_out - o0); end
        if (outs[o0] !== 8'h02)   begin n_fail++; $display("FAIL loop_out0: got %h exp 02", outs[o0]); end
        if (outs[o0+1] !== 8'h01) begin n_fail++; $display("FAIL loop_out1: got %h exp 01", outs[o0+1]); end
        if (outs[o0+2] !== 8'h00) begin n_fail++; $display("FAIL loop_out2: got %h exp 00", outs[o0+2]); end
    endtask

    task automatic test_branch_wrap();
        bit seen;
        hold_reset(0);
        prog[0]   = 16'h91FF;
        prog[255] = 16'h8000;
        release_reset();
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(negedge clk);
            if (mif.mem_req && !mif.mem_we && mif.mem_addr == 8'hFF) seen = 1'b1;
        end
        for (int c = 0; c < 20 && seen && mif.mem_req; c++) @(negedge clk);
        for (int c = 0; c < 20 && seen && !mif.mem_req; c++) @(negedge clk);
        n_checks += 3;
        if (!seen) begin n_fail++; $display("FAIL br_fetch_ff: no fetch at ff seen, exp one"); end
        if (mif.mem_addr !== 8'h00 || mif.mem_req !== 1'b1) begin
            n_fail++; $display("FAIL br_wrap_addr: got req=%b addr=%h exp req=1 addr=00", mif.mem_req, mif.mem_addr);
        end
        if (pc_dbg !== 8'h00) begin n_fail++; $display("FAIL br_wrap_pc: got %h exp 00", pc_dbg); end
    endtask

    task automatic test_reset_mid_request();
        int  o0;
        bit  seen;
        hold_reset(20);
        prog[0] = 16'h115A; prog[1] = 16'h1433; prog[2] = 16'h3100;
        release_reset();
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (mif.mem_req && mif.mem_we) seen = 1'b1;
        end
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (!seen) begin n_fail++; $display("FAIL rmid_store_req: no store request seen, exp one"); end
        if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL rmid_req_drop: got %b exp 0", mif.mem_req); end
        if (mif.mem_we !== 1'b0)  begin n_fail++; $display("FAIL rmid_we_drop: got %b exp 0", mif.mem_we); end
        hold_reset(0);
        prog[0] = 16'hA010; prog[1] = 16'hA040; prog[2] = 16'hF000;
        o0 = n_out;
        release_reset();
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mif.mem_req) seen = 1'b1;
        end
        n_checks++;
        if (!seen || mif.mem_addr !== 8'h00) begin
            n_fail++; $display("FAIL rmid_fetch_pc: got req=%b addr=%h exp req=1 addr=00", seen, mif.mem_addr);
        end
        wait_halt(100, "rmid");
        n_checks += 3;
        if (n_out - o0 != 2)    begin n_fail++; $display("FAIL rmid_out_count: got %0d exp 2", n_out - o0); end
        if (outs[o0] !== 8'h00)   begin n_fail++; $display("FAIL rmid_r1_clear: got %h exp 00", outs[o0]); end
        if (outs[o0+1] !== 8'h00) begin n_fail++; $display("FAIL rmid_r4_clear: got %h exp 00", outs[o0+1]); end
    endtask

    task automatic test_illegal_opcode();
        int o0;
        hold_reset(0);
        prog[0] = 16'h1107; prog[1] = 16'hB000; prog[2] = 16'hA010; prog[3] = 16'hF000;
        o0 = n_out;
        release_reset();
        wait_halt(100, "illegal");
`ifdef PROC_MC_ILLEGAL_TRAP_EN
        n_checks += 2;
        if (pc_dbg !== 8'h01)   begin n_fail++; $display("FAIL trap_pc: got %h exp 01", pc_dbg); end
        if (n_out - o0 != 0)    begin n_fail++; $display("FAIL trap_no_out: got %0d exp 0", n_out - o0); end
`else
        n_checks += 2;
        if (n_out - o0 != 1)    begin n_fail++; $display("FAIL nop_out_count: got %0d exp 1", n_out - o0); end
        if (outs[o0] !== 8'h07) begin n_fail++; $display("FAIL nop_out_data: got %h exp 07", outs[o0]); end
`endif
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_ld_st();
        test_wrap_arith();
        test_countdown();
        test_branch_wrap();
        test_reset_mid_request();
        test_illegal_opcode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
